shift_register_univ: RTL and testbench
======================================

Name: shift_register_univ

Overview:
- Parametrised universal shift register, the successor to the fixed 4-bit right-shift register.
- Configurable width; supports hold, shift right, shift left and parallel load.
- Has an auto-burst engine: shifts a programmed number of bits, then flags completion.
- Used as the serialiser/deserialiser front end for bit-serial links and for lab datapath exercises.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- CNT_W, 4, burst counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- c  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- en  input  1  manual-mode enable; ignored while busy.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sin_r  input  1  serial input entering q[WIDTH-1] on a right shift.
- sin_l  input  1  serial input entering q[0] on a left shift.
- d  input  WIDTH  parallel load data.
- start  input  1  begin auto-burst (sampled only when idle).
- dir  input  1  burst direction: 0 right, 1 left.
- len  input  CNT_W  burst length in shifts.
- rot  input  1  rotate select; only used with SHREG_ROTATE_EN.
- q  output  WIDTH  register contents.
- sout_r  output  1  equals q[0], the bit leaving on a right shift.
- sout_l  output  1  equals q[WIDTH-1], the bit leaving on a left shift.
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle pulse after the final burst shift.
- cnt  output  CNT_W  shifts remaining in the current burst.

Behaviour:
- Reset (asynchronous, takes effect immediately): q=0, busy=0, done=0, cnt=0, FSM=IDLE. Reset asserted mid-burst aborts the burst with no done pulse.
- Right shift: q[i]<=q[i+1] for i<WIDTH-1, and q[WIDTH-1]<=sin_r.
- Left shift: q[i]<=q[i-1] for i>0, and q[0]<=sin_l.
- Load: q<=d, all bits in one cycle.
- Hold, or en=0 in IDLE: q unchanged.
- All register updates are non-blocking and take effect at the rising edge; outputs are registered, so latency is 1 cycle.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Manual operation per en/mode.
  - If start=1 and len≠0: latch dir, cnt<=len, busy<=1, go to SHIFT. That edge performs no shift.
  - start has priority over manual en in the same cycle; the manual op is dropped.
  - start=1 with len=0: no state change, no done, and the manual op still applies.
- SHIFT:
  - Each cycle: one shift in the latched dir, using sin_r or sin_l; cnt<=cnt-1.
  - When cnt==1: this is the last shift; busy<=0, done<=1, go to DONE.
  - en, mode, start, len and dir are ignored.
- DONE:
  - done is high for exactly this one cycle.
  - Next edge: done<=0, return to IDLE.
  - start is ignored in DONE; a new burst may be issued from IDLE the following cycle.
- A burst of len=n occupies n SHIFT cycles; busy falls and done rises on the same edge.
- len>WIDTH is legal; extra shifts keep pulling serial input.
- sout_r and sout_l are combinational from q.

Optional Feature:
- Macro: SHREG_ROTATE_EN.
- Defined: when rot=1, right shift loads q[WIDTH-1]<=q[0] and left shift loads q[0]<=q[WIDTH-1]; sin_r and sin_l are ignored. Applies in both manual and burst modes; a burst latches rot at start.
- Undefined: rot is ignored (port kept, unconnected internally); shifts always take sin_r/sin_l.

Test Plan:
- Reset: drive q to 8'hA5 via load, assert rst mid-cycle → q=8'h00 and busy=0 before the next edge.
- Manual right shift, WIDTH=4: load 4'b0000, then 4 cycles of mode=01 with sin_r=1,0,1,1 → q=4'b1101, sout_r=1.
- Manual left/load/hold: load 8'h81, one left shift with sin_l=0 → 8'h02; mode=00 for 3 cycles → stays 8'h02; en=0 with mode=11 → no load.
- Burst: q=8'hF0, start with dir=0, len=3, sin_r=0 → busy for exactly 3 cycles, q=8'h1E, done pulses 1 cycle, cnt counts 3,2,1,0; start held during the burst is ignored.
- Edge cases: start with len=0 → no busy/done; start together with en/mode=11 → burst wins and d is not loaded; rst asserted during SHIFT → no done, q=0, next start works normally.
- SHREG_ROTATE_EN build: q=8'h81, rot=1, burst dir=1, len=8 → q returns to 8'h81 and done pulses. Without the macro, the same run with sin_l=0 → q=8'h00.

Source files
------------

// File: rtl/shift_register_univ.sv
// rtl/shift_register_univ.sv - parametrised universal shift register with auto-burst engine
//
// Purpose:
//   Hold / shift right / shift left / parallel load register with an
//   auto-burst engine that performs a programmed number of shifts and then
//   pulses done for one cycle.
//
// Optional feature macro: SHREG_ROTATE_EN
//   Defined   : rot=1 turns shifts into rotates (serial inputs ignored);
//               a burst latches rot when it starts.
//   Undefined : rot is accepted but has no effect.
//
// Ports:
//   c       in   clock, rising edge
//   rst     in   asynchronous active-high reset
//   en      in   manual-mode enable (ignored while a burst runs)
//   mode    in   00 hold, 01 shift right, 10 shift left, 11 parallel load
//   sin_r   in   serial bit entering q[WIDTH-1] on a right shift
//   sin_l   in   serial bit entering q[0] on a left shift
//   d       in   parallel load data
//   start   in   begin auto-burst (sampled only in IDLE)
//   dir     in   burst direction: 0 right, 1 left
//   len     in   burst length in shifts
//   rot     in   rotate select (SHREG_ROTATE_EN builds only)
//   q       out  register contents
//   sout_r  out  q[0]
//   sout_l  out  q[WIDTH-1]
//   busy    out  burst in progress
//   done    out  one-cycle pulse after the final burst shift
//   cnt     out  shifts remaining in the current burst

module shift_register_univ #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             c,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] len,
  input  logic             rot,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_dir;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_dir_nxt;
  logic             w_do_shift;
  logic             w_shift_left;
  logic             w_fill_r;
  logic             w_fill_l;

`ifdef SHREG_ROTATE_EN
  logic r_rot;
  logic w_rot_nxt;
  logic w_use_rot;
`else
  logic w_unused_rot;
  assign w_unused_rot = rot;
`endif

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dir   <= 1'b0;
`ifdef SHREG_ROTATE_EN
      r_rot   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_dir   <= w_dir_nxt;
`ifdef SHREG_ROTATE_EN
      r_rot   <= w_rot_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_q_nxt      = r_q;
    w_cnt_nxt    = r_cnt;
    w_busy_nxt   = r_busy;
    w_done_nxt   = r_done;
    w_dir_nxt    = r_dir;
    w_do_shift   = 1'b0;
    w_shift_left = 1'b0;
`ifdef SHREG_ROTATE_EN
    w_rot_nxt    = r_rot;
    w_use_rot    = 1'b0;
`endif

    case (r_state)
      IDLE: begin
        // A burst request wins over any manual op in the same cycle; the
        // launching edge only arms the engine and does not shift.
        if (start && (len != '0)) begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = len;
          w_busy_nxt  = 1'b1;
          w_dir_nxt   = dir;
`ifdef SHREG_ROTATE_EN
          w_rot_nxt   = rot;
`endif
        end else if (en) begin
          case (mode)
            2'b01: begin
              w_do_shift   = 1'b1;
              w_shift_left = 1'b0;
`ifdef SHREG_ROTATE_EN
              w_use_rot    = rot;
`endif
            end
            2'b10: begin
              w_do_shift   = 1'b1;
              w_shift_left = 1'b1;
`ifdef SHREG_ROTATE_EN
              w_use_rot    = rot;
`endif
            end
            2'b11:   w_q_nxt = d;
            default: w_q_nxt = r_q;
          endcase
        end
      end

      SHIFT: begin
        w_do_shift   = 1'b1;
        w_shift_left = r_dir;
`ifdef SHREG_ROTATE_EN
        w_use_rot    = r_rot;
`endif
        w_cnt_nxt    = r_cnt - 1'b1;
        if (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          w_state_nxt = DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b0;
      end

      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
      end
    endcase

`ifdef SHREG_ROTATE_EN
    w_fill_r = w_use_rot ? r_q[0]       : sin_r;
    w_fill_l = w_use_rot ? r_q[WIDTH-1] : sin_l;
`else
    w_fill_r = sin_r;
    w_fill_l = sin_l;
`endif

    if (w_do_shift) begin
      if (w_shift_left) w_q_nxt = {r_q[WIDTH-2:0], w_fill_l};
      else              w_q_nxt = {w_fill_r, r_q[WIDTH-1:1]};
    end
  end

  assign q      = r_q;
  assign sout_r = r_q[0];
  assign sout_l = r_q[WIDTH-1];
  assign busy   = r_busy;
  assign done   = r_done;
  assign cnt    = r_cnt;

endmodule

// File: tb/tb_shift_register_univ.sv
// tb/tb_shift_register_univ.sv - randomized model-checked bench for shift_register_univ

module tb_shift_register_univ;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          c = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          sin_r = 1'b0;
  logic          sin_l = 1'b0;
  logic [W-1:0]  d = '0;
  logic          start = 1'b0;
  logic          dir = 1'b0;
  logic [CW-1:0] len = '0;
  logic          rot = 1'b0;
  logic [W-1:0]  q;
  logic          sout_r, sout_l, busy, done;
  logic [CW-1:0] cnt;

  int n_tests = 0;
  int n_fail  = 0;

  shift_register_univ #(.WIDTH(W), .CNT_W(CW)) dut (
    .c(c), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .d(d), .start(start), .dir(dir), .len(len), .rot(rot),
    .q(q), .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done), .cnt(cnt)
  );

  always #5 c = ~c;

  // Behavioural model: the register as an integer, the burst as a count of
  // shifts still owed, and a flag for the single cycle after it finishes.
  int m_q;
  int m_left;      // shifts still to perform; 0 when no burst
  bit m_flag_done;
  bit m_bdir;
  bit m_brot;

  function automatic bit rot_active(input bit r);
`ifdef SHREG_ROTATE_EN
    return r;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int shr(input int v, input bit s, input bit r);
    int in_bit;
    in_bit = rot_active(r) ? (v % 2) : int'(s);
    return (v / 2) + in_bit * (1 << (W - 1));
  endfunction

  function automatic int shl(input int v, input bit s, input bit r);
    int in_bit;
    in_bit = rot_active(r) ? ((v >> (W - 1)) % 2) : int'(s);
    return ((v * 2) % (1 << W)) + in_bit;
  endfunction

  always @(posedge c or posedge rst) begin
    if (rst) begin
      m_q         <= 0;
      m_left      <= 0;
      m_flag_done <= 1'b0;
      m_bdir      <= 1'b0;
      m_brot      <= 1'b0;
    end else if (m_flag_done) begin
      m_flag_done <= 1'b0;
    end else if (m_left > 0) begin
      m_q    <= m_bdir ? shl(m_q, sin_l, m_brot) : shr(m_q, sin_r, m_brot);
      m_left <= m_left - 1;
      if (m_left == 1) m_flag_done <= 1'b1;
    end else if (start && int'(len) > 0) begin
      m_left <= int'(len);
      m_bdir <= dir;
      m_brot <= rot;
    end else if (en) begin
      if (mode == 2'b01)      m_q <= shr(m_q, sin_r, rot);
      else if (mode == 2'b10) m_q <= shl(m_q, sin_l, rot);
      else if (mode == 2'b11) m_q <= int'(d);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous compare against the model on every falling edge.
  always @(negedge c) begin
    chk("q",      int'(q),      m_q);
    chk("sout_r", int'(sout_r), m_q % 2);
    chk("sout_l", int'(sout_l), (m_q >> (W - 1)) % 2);
    chk("busy",   int'(busy),   int'(m_left > 0));
    chk("done",   int'(done),   int'(m_flag_done));
    chk("cnt",    int'(cnt),    m_left);
  end

  task automatic tick();
    @(negedge c);
    #1;
  endtask

  task automatic quiet();
    en = 1'b0; mode = 2'b00; start = 1'b0; sin_r = 1'b0; sin_l = 1'b0;
    dir = 1'b0; len = '0; rot = 1'b0; d = '0;
  endtask

  task automatic load(input logic [W-1:0] v);
    quiet(); en = 1'b1; mode = 2'b11; d = v;
    tick();
    quiet();
  endtask

  logic [3:0] pat;

  initial begin
    quiet();
    rst = 1'b1;
    tick(); tick();
    chk("reset_q", int'(q), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    tick();

    // Asynchronous reset mid-cycle
    load(8'hA5);
    chk("load_a5", int'(q), 8'hA5);
    @(posedge c); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_q", int'(q), 0);
    chk("async_rst_busy", int'(busy), 0);
    tick();
    rst = 1'b0;
    tick();

    // Manual right shifts: 1,0,1,1 into a cleared register -> 8'hD0
    load(8'h00);
    pat = 4'b1101; // bit 0 shifted first
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; mode = 2'b01; sin_r = pat[i];
      tick();
    end
    quiet();
    chk("shr_pattern", int'(q), 8'hD0);
    chk("shr_sout_r", int'(sout_r), 0);

    // Left shift, hold, disabled load
    load(8'h81);
    en = 1'b1; mode = 2'b10; sin_l = 1'b0;
    tick();
    chk("shl_81", int'(q), 8'h02);
    mode = 2'b00;
    tick(); tick(); tick();
    chk("hold", int'(q), 8'h02);
    en = 1'b0; mode = 2'b11; d = 8'hFF;
    tick();
    chk("en0_noload", int'(q), 8'h02);
    quiet();

    // Burst: F0, right by 3 with zeros -> 1E; start held throughout
    load(8'hF0);
    start = 1'b1; dir = 1'b0; len = 4'd3; sin_r = 1'b0;
    tick();
    chk("burst_cnt3", int'(cnt), 3);
    chk("burst_busy", int'(busy), 1);
    chk("burst_nodone", int'(done), 0);
    tick();
    chk("burst_cnt2", int'(cnt), 2);
    tick();
    chk("burst_cnt1", int'(cnt), 1);
    tick();
    chk("burst_cnt0", int'(cnt), 0);
    chk("burst_q", int'(q), 8'h1E);
    chk("burst_done", int'(done), 1);
    chk("burst_busy_fall", int'(busy), 0);
    tick();
    chk("burst_done_pulse", int'(done), 0);
    chk("start_in_done_ignored", int'(busy), 0);
    quiet();
    tick();

    // start with len=0: manual load still applies, no burst
    start = 1'b1; len = 4'd0; en = 1'b1; mode = 2'b11; d = 8'h3C;
    tick();
    chk("len0_busy", int'(busy), 0);
    chk("len0_load", int'(q), 8'h3C);
    quiet();
    tick();
    chk("len0_done", int'(done), 0);

    // start beats manual load
    start = 1'b1; len = 4'd2; en = 1'b1; mode = 2'b11; d = 8'hFF;
    tick();
    chk("start_prio_q", int'(q), 8'h3C);
    chk("start_prio_busy", int'(busy), 1);
    quiet();
    tick(); tick(); tick();

    // Reset during SHIFT aborts, next burst works
    start = 1'b1; len = 4'd5; sin_r = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("abort_q", int'(q), 0);
    chk("abort_done", int'(done), 0);
    tick();
    rst = 1'b0;
    quiet();
    tick();
    start = 1'b1; len = 4'd1; sin_r = 1'b1;
    tick();
    start = 1'b0;
    chk("after_abort_busy", int'(busy), 1);
    tick();
    chk("after_abort_done", int'(done), 1);
    chk("after_abort_q", int'(q), 8'h80);
    quiet();
    tick();

    // Rotating burst (or plain left shifts of zeros without the feature)
    load(8'h81);
    start = 1'b1; dir = 1'b1; len = 4'd8; rot = 1'b1; sin_l = 1'b0;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("rot_done", int'(done), 1);
`ifdef SHREG_ROTATE_EN
    chk("rot_q", int'(q), 8'h81);
`else
    chk("rot_q", int'(q), 8'h00);
`endif
    quiet();
    tick();

    // Randomized traffic checked by the model each cycle
    for (int i = 0; i < 3000; i++) begin
      en    = 1'($urandom_range(0, 1));
      mode  = 2'($urandom_range(0, 3));
      sin_r = 1'($urandom_range(0, 1));
      sin_l = 1'($urandom_range(0, 1));
      d     = W'($urandom);
      start = ($urandom_range(0, 7) == 0);
      dir   = 1'($urandom_range(0, 1));
      len   = CW'($urandom_range(0, 15));
      rot   = 1'($urandom_range(0, 1));
      rst   = ($urandom_range(0, 149) == 0);
      tick();
      rst   = 1'b0;
    end
    quiet();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
